// File: rtl/ibex_pkg.sv
// Shared types for the EX issue controller slice: ALU / MUL-DIV operator encodings,
// M-extension variant selector and the issue-controller state enum.
// Latency: n/a (types only). Backpressure: n/a.
package ibex_pkg;

  typedef enum integer {
    RV32MNone        = 0,
    RV32MSlow        = 1,
    RV32MFast        = 2,
    RV32MSingleCycle = 3
  } rv32m_e;

  typedef enum logic [6:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_XOR,
    ALU_OR,
    ALU_AND,
    ALU_SLL,
    ALU_SRL,
    ALU_SRA,
    ALU_SLT,
    ALU_SLTU
  } alu_op_e;

  typedef enum logic [1:0] {
    MD_OP_MULL,
    MD_OP_MULH,
    MD_OP_DIV,
    MD_OP_REM
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } ex_issue_state_e;

  localparam int unsigned ImdValWidth = 34;

  // True when the configuration carries a MUL/DIV unit at all.
  function automatic logic md_present(rv32m_e variant);
    return variant != RV32MNone;
  endfunction

endpackage

// File: rtl/ibex_ex_imd_val_reg.sv
// Two 34-bit intermediate-value registers that EX reads back on later cycles of a multi-cycle op.
// Latency: write visible on q_o one cycle after we_i. Backpressure: none (always accepts writes).
// Ports: clk_i/rst_i, clear_i (sync clear, wins over writes), we_i[1:0], d_i[2], q_o[2].
module ibex_ex_imd_val_reg
  import ibex_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   clear_i,
  input  logic [1:0]             we_i,
  input  logic [ImdValWidth-1:0] d_i [2],
  output logic [ImdValWidth-1:0] q_o [2]
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      q_o[0] <= '0;
      q_o[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (clear_i) begin
          q_o[i] <= '0;
        end else if (we_i[i]) begin
          q_o[i] <= d_i[i];
        end
      end
    end
  end

endmodule

// File: rtl/ibex_ex_issue_ctrl.sv
// Issue-side controller for EX: holds one instruction's operands over multi-cycle execution,
// drives ALU/MUL-DIV strobes, owns the intermediate-value regs, and hands the result to writeback.
// Latency: accept at N, EXEC from N+1, wb_valid one cycle after ex_valid. Backpressure: wb_ready
// low holds the result in WB and blocks issue; a retiring WB cycle can accept the next instruction.
// Ports: issue_* (ID side), alu_*/multdiv_*/mult_*/div_*/imd_val_* (EX side), ex_valid_i/result_ex_i,
// wb_* (writeback handshake + payload), flush_i, exec_cycles_o (cycles spent in EXEC).
module ibex_ex_issue_ctrl
  import ibex_pkg::*;
#(
  parameter rv32m_e      RV32M    = RV32MFast,
  parameter int unsigned CntWidth = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_i,

  input  logic                   issue_valid_i,
  output logic                   issue_ready_o,
  input  alu_op_e                issue_alu_op_i,
  input  md_op_e                 issue_md_op_i,
  input  logic                   issue_mult_i,
  input  logic                   issue_div_i,
  input  logic [1:0]             issue_signed_mode_i,
  input  logic [31:0]            issue_op_a_i,
  input  logic [31:0]            issue_op_b_i,
  input  logic [4:0]             issue_rd_i,
  input  logic                   issue_we_i,
  input  logic                   flush_i,

  output alu_op_e                alu_operator_o,
  output logic [31:0]            alu_operand_a_o,
  output logic [31:0]            alu_operand_b_o,
  output logic                   alu_instr_first_cycle_o,

  output md_op_e                 multdiv_operator_o,
  output logic [1:0]             multdiv_signed_mode_o,
  output logic [31:0]            multdiv_operand_a_o,
  output logic [31:0]            multdiv_operand_b_o,
  output logic                   mult_en_o,
  output logic                   div_en_o,
  output logic                   mult_sel_o,
  output logic                   div_sel_o,
  output logic                   multdiv_ready_id_o,

  input  logic [1:0]             imd_val_we_i,
  input  logic [ImdValWidth-1:0] imd_val_d_i [2],
  output logic [ImdValWidth-1:0] imd_val_q_o [2],

  input  logic [31:0]            result_ex_i,
  input  logic                   ex_valid_i,

  output logic                   wb_valid_o,
  input  logic                   wb_ready_i,
  output logic [4:0]             wb_rd_o,
  output logic                   wb_we_o,
  output logic [31:0]            wb_data_o,

  output logic [CntWidth-1:0]    exec_cycles_o
);

  localparam logic MdEnabled = md_present(RV32M);

  ex_issue_state_e     state_q;
  alu_op_e             alu_op_q;
  md_op_e              md_op_q;
  logic [1:0]          signed_q;
  logic [31:0]         op_a_q;
  logic [31:0]         op_b_q;
  logic [4:0]          rd_q;
  logic                we_q;

  logic                first_q;
  logic                mult_en_q;
  logic                div_en_q;
  logic                mult_sel_q;
  logic                div_sel_q;
  logic                md_ready_q;

  logic                wb_valid_q;
  logic [4:0]          wb_rd_q;
  logic                wb_we_q;
  logic [31:0]         wb_data_q;
  logic [CntWidth-1:0] cnt_q;

  logic                accept;
  logic                imd_clear;
  logic [1:0]          imd_we;

  // A retiring WB cycle doubles as an issue slot, giving back-to-back issue without a bubble.
  assign issue_ready_o = ~flush_i & ((state_q == IDLE) | ((state_q == WB) & wb_ready_i));
  assign accept        = issue_valid_i & issue_ready_o;

  // New instruction starts with clean intermediate state; flush discards it.
  assign imd_clear = accept | flush_i;
  assign imd_we    = (state_q == EXEC) ? imd_val_we_i : 2'b00;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      alu_op_q   <= ALU_ADD;
      md_op_q    <= MD_OP_MULL;
      signed_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      first_q    <= 1'b0;
      mult_en_q  <= 1'b0;
      div_en_q   <= 1'b0;
      mult_sel_q <= 1'b0;
      div_sel_q  <= 1'b0;
      md_ready_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      wb_data_q  <= '0;
      cnt_q      <= '0;
    end else if (accept) begin
      state_q    <= EXEC;
      alu_op_q   <= issue_alu_op_i;
      md_op_q    <= issue_md_op_i;
      signed_q   <= issue_signed_mode_i;
      op_a_q     <= issue_op_a_i;
      op_b_q     <= issue_op_b_i;
      rd_q       <= issue_rd_i;
      we_q       <= issue_we_i;
      first_q    <= 1'b1;
      mult_en_q  <= issue_mult_i & MdEnabled;
      div_en_q   <= issue_div_i & MdEnabled;
      mult_sel_q <= issue_mult_i & MdEnabled;
      div_sel_q  <= issue_div_i & MdEnabled;
      md_ready_q <= 1'b1;
      wb_valid_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        EXEC: begin
          first_q <= 1'b0;
          if (cnt_q != '1) begin
            cnt_q <= cnt_q + CntWidth'(1);
          end
          if (flush_i) begin
            state_q    <= IDLE;
            mult_en_q  <= 1'b0;
            div_en_q   <= 1'b0;
            mult_sel_q <= 1'b0;
            div_sel_q  <= 1'b0;
            md_ready_q <= 1'b0;
          end else if (ex_valid_i) begin
            state_q    <= WB;
            mult_en_q  <= 1'b0;
            div_en_q   <= 1'b0;
            md_ready_q <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_data_q  <= result_ex_i;
            wb_rd_q    <= rd_q;
            wb_we_q    <= we_q;
          end
        end
        WB: begin
          // Flush with wb_ready high still retires: the handshake completes this cycle.
          if (flush_i | wb_ready_i) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
            mult_sel_q <= 1'b0;
            div_sel_q  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign alu_operator_o          = alu_op_q;
  assign alu_operand_a_o         = op_a_q;
  assign alu_operand_b_o         = op_b_q;
  assign alu_instr_first_cycle_o = first_q;

  assign multdiv_operator_o      = md_op_q;
  assign multdiv_signed_mode_o   = signed_q;
  assign multdiv_operand_a_o     = op_a_q;
  assign multdiv_operand_b_o     = op_b_q;
  assign mult_en_o               = mult_en_q;
  assign div_en_o                = div_en_q;
  assign mult_sel_o              = mult_sel_q;
  assign div_sel_o               = div_sel_q;
  assign multdiv_ready_id_o      = md_ready_q;

  assign wb_valid_o              = wb_valid_q;
  assign wb_rd_o                 = wb_rd_q;
  assign wb_we_o                 = wb_we_q;
  assign wb_data_o               = wb_data_q;
  assign exec_cycles_o           = cnt_q;

  ibex_ex_imd_val_reg u_imd_val_reg (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (imd_clear),
    .we_i    (imd_we),
    .d_i     (imd_val_d_i),
    .q_o     (imd_val_q_o)
  );

endmodule

// File: tb/tb_ibex_ex_issue_ctrl.sv
// Bench for ibex_ex_issue_ctrl: a RV32MFast instance and a RV32MNone instance share all stimulus.
// Expected values come from a transaction-level model (held instruction, result, exec length).
module tb_ibex_ex_issue_ctrl;
  import ibex_pkg::*;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic        issue_valid_i, flush_i, issue_mult_i, issue_div_i, issue_we_i;
  alu_op_e     issue_alu_op_i;
  md_op_e      issue_md_op_i;
  logic [1:0]  issue_signed_mode_i;
  logic [31:0] issue_op_a_i, issue_op_b_i;
  logic [4:0]  issue_rd_i;
  logic [1:0]  imd_val_we_i;
  logic [33:0] imd_val_d_i [2];
  logic [31:0] result_ex_i;
  logic        ex_valid_i, wb_ready_i;

  // RV32MFast instance outputs
  logic        issue_ready_o, alu_instr_first_cycle_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o;
  logic        multdiv_ready_id_o, wb_valid_o, wb_we_o;
  alu_op_e     alu_operator_o;
  md_op_e      multdiv_operator_o;
  logic [1:0]  multdiv_signed_mode_o;
  logic [31:0] alu_operand_a_o, alu_operand_b_o, multdiv_operand_a_o, multdiv_operand_b_o, wb_data_o;
  logic [33:0] imd_val_q_o [2];
  logic [4:0]  wb_rd_o;
  logic [5:0]  exec_cycles_o;

  // RV32MNone instance outputs
  logic        n_issue_ready, n_first, n_mult_en, n_div_en, n_mult_sel, n_div_sel;
  logic        n_md_ready, n_wb_valid, n_wb_we;
  alu_op_e     n_alu_op;
  md_op_e      n_md_op;
  logic [1:0]  n_signed;
  logic [31:0] n_alu_a, n_alu_b, n_md_a, n_md_b, n_wb_data;
  logic [33:0] n_imd_q [2];
  logic [4:0]  n_wb_rd;
  logic [5:0]  n_exec_cycles;

  ibex_ex_issue_ctrl #(.RV32M(RV32MFast), .CntWidth(6)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_alu_op_i(issue_alu_op_i), .issue_md_op_i(issue_md_op_i),
    .issue_mult_i(issue_mult_i), .issue_div_i(issue_div_i),
    .issue_signed_mode_i(issue_signed_mode_i),
    .issue_op_a_i(issue_op_a_i), .issue_op_b_i(issue_op_b_i),
    .issue_rd_i(issue_rd_i), .issue_we_i(issue_we_i), .flush_i(flush_i),
    .alu_operator_o(alu_operator_o), .alu_operand_a_o(alu_operand_a_o),
    .alu_operand_b_o(alu_operand_b_o), .alu_instr_first_cycle_o(alu_instr_first_cycle_o),
    .multdiv_operator_o(multdiv_operator_o), .multdiv_signed_mode_o(multdiv_signed_mode_o),
    .multdiv_operand_a_o(multdiv_operand_a_o), .multdiv_operand_b_o(multdiv_operand_b_o),
    .mult_en_o(mult_en_o), .div_en_o(div_en_o), .mult_sel_o(mult_sel_o), .div_sel_o(div_sel_o),
    .multdiv_ready_id_o(multdiv_ready_id_o),
    .imd_val_we_i(imd_val_we_i), .imd_val_d_i(imd_val_d_i), .imd_val_q_o(imd_val_q_o),
    .result_ex_i(result_ex_i), .ex_valid_i(ex_valid_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_we_o(wb_we_o), .wb_data_o(wb_data_o),
    .exec_cycles_o(exec_cycles_o)
  );

  ibex_ex_issue_ctrl #(.RV32M(RV32MNone), .CntWidth(6)) dut_none (
    .clk_i(clk), .rst_i(rst_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(n_issue_ready),
    .issue_alu_op_i(issue_alu_op_i), .issue_md_op_i(issue_md_op_i),
    .issue_mult_i(issue_mult_i), .issue_div_i(issue_div_i),
    .issue_signed_mode_i(issue_signed_mode_i),
    .issue_op_a_i(issue_op_a_i), .issue_op_b_i(issue_op_b_i),
    .issue_rd_i(issue_rd_i), .issue_we_i(issue_we_i), .flush_i(flush_i),
    .alu_operator_o(n_alu_op), .alu_operand_a_o(n_alu_a),
    .alu_operand_b_o(n_alu_b), .alu_instr_first_cycle_o(n_first),
    .multdiv_operator_o(n_md_op), .multdiv_signed_mode_o(n_signed),
    .multdiv_operand_a_o(n_md_a), .multdiv_operand_b_o(n_md_b),
    .mult_en_o(n_mult_en), .div_en_o(n_div_en), .mult_sel_o(n_mult_sel), .div_sel_o(n_div_sel),
    .multdiv_ready_id_o(n_md_ready),
    .imd_val_we_i(imd_val_we_i), .imd_val_d_i(imd_val_d_i), .imd_val_q_o(n_imd_q),
    .result_ex_i(result_ex_i), .ex_valid_i(ex_valid_i),
    .wb_valid_o(n_wb_valid), .wb_ready_i(wb_ready_i),
    .wb_rd_o(n_wb_rd), .wb_we_o(n_wb_we), .wb_data_o(n_wb_data),
    .exec_cycles_o(n_exec_cycles)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Model of the instruction currently held by the controller, and of its imd registers.
  alu_op_e     e_alu;
  md_op_e      e_md;
  logic        e_mult, e_div, e_we;
  logic [1:0]  e_sm;
  logic [31:0] e_a, e_b;
  logic [4:0]  e_rd;
  logic [33:0] m_imd0, m_imd1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] sat(input int v);
    return (v > 63) ? 6'd63 : 6'(v);
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_instr(input int kind);
    e_alu  = alu_op_e'(7'($urandom_range(0, 9)));
    e_mult = (kind == 1);
    e_div  = (kind == 2);
    e_md   = md_op_e'(2'((kind == 2) ? $urandom_range(2, 3) : $urandom_range(0, 1)));
    e_sm   = 2'($urandom);
    e_a    = $urandom;
    e_b    = $urandom;
    e_rd   = 5'($urandom);
    e_we   = 1'($urandom);
  endtask

  task automatic drive_issue();
    issue_alu_op_i      = e_alu;
    issue_md_op_i       = e_md;
    issue_mult_i        = e_mult;
    issue_div_i         = e_div;
    issue_signed_mode_i = e_sm;
    issue_op_a_i        = e_a;
    issue_op_b_i        = e_b;
    issue_rd_i          = e_rd;
    issue_we_i          = e_we;
    issue_valid_i       = 1'b1;
  endtask

  task automatic accept();
    drive_issue();
    #1;
    chk("issue_ready_accept", {issue_ready_o, n_issue_ready}, 2'b11);
    cyc();
    issue_valid_i = 1'b0;
    issue_op_a_i  = $urandom;
    issue_op_b_i  = $urandom;
    wb_ready_i    = 1'b0;
    m_imd0 = '0;
    m_imd1 = '0;
  endtask

  // Runs EXEC cycles; ex_valid on cycle len, optional imd write on cycle wcyc, optional flush.
  task automatic exec_phase(input int len, input logic [31:0] res, input int wcyc,
                            input logic [1:0] wmask, input logic [33:0] w0,
                            input logic [33:0] w1, input int flush_at);
    bit stop;
    logic f;
    stop = 1'b0;
    for (int k = 1; k <= len && !stop; k++) begin
      ex_valid_i     = (k == len) || (k == flush_at);
      result_ex_i    = (k == len) ? res : $urandom;
      flush_i        = (k == flush_at);
      imd_val_we_i   = (k == wcyc) ? wmask : 2'b00;
      imd_val_d_i[0] = w0;
      imd_val_d_i[1] = w1;
      f = (k == 1);
      #1;
      chk("first_cycle", {alu_instr_first_cycle_o, n_first}, {f, f});
      chk("md_enables", {mult_en_o, div_en_o, n_mult_en, n_div_en}, {e_mult, e_div, 2'b00});
      chk("md_selects", {mult_sel_o, div_sel_o, n_mult_sel, n_div_sel}, {e_mult, e_div, 2'b00});
      chk("md_ready_exec", {multdiv_ready_id_o, n_md_ready}, 2'b11);
      chk("wb_valid_exec", {wb_valid_o, n_wb_valid, issue_ready_o, n_issue_ready}, 4'b0000);
      chk("alu_operands", {alu_operand_a_o, alu_operand_b_o, n_alu_a, n_alu_b}, {e_a, e_b, e_a, e_b});
      chk("md_operands", {multdiv_operand_a_o, multdiv_operand_b_o, n_md_a, n_md_b},
          {e_a, e_b, e_a, e_b});
      chk("operators", {alu_operator_o, multdiv_operator_o, multdiv_signed_mode_o,
                        n_alu_op, n_md_op, n_signed}, {e_alu, e_md, e_sm, e_alu, e_md, e_sm});
      chk("imd_q_exec", {imd_val_q_o[0], imd_val_q_o[1]}, {m_imd0, m_imd1});
      chk("n_imd_q_exec", {n_imd_q[0], n_imd_q[1]}, {m_imd0, m_imd1});
      chk("exec_cycles_run", {exec_cycles_o, n_exec_cycles}, {sat(k - 1), sat(k - 1)});
      if (k == wcyc) begin
        if (wmask[0]) m_imd0 = w0;
        if (wmask[1]) m_imd1 = w1;
      end
      cyc();
      if (k == flush_at) stop = 1'b1;
    end
    ex_valid_i   = 1'b0;
    flush_i      = 1'b0;
    imd_val_we_i = 2'b00;
  endtask

  task automatic check_wb(input logic [31:0] res, input int len);
    #1;
    chk("wb_valid", {wb_valid_o, n_wb_valid}, 2'b11);
    chk("wb_data", {wb_data_o, n_wb_data}, {res, res});
    chk("wb_rd_we", {wb_rd_o, wb_we_o, n_wb_rd, n_wb_we}, {e_rd, e_we, e_rd, e_we});
    chk("exec_cycles_wb", {exec_cycles_o, n_exec_cycles}, {sat(len), sat(len)});
    chk("wb_strobes", {mult_en_o, div_en_o, multdiv_ready_id_o, alu_instr_first_cycle_o,
                       n_mult_en, n_div_en, n_md_ready, n_first}, 8'h00);
    chk("wb_selects", {mult_sel_o, div_sel_o, n_mult_sel, n_div_sel}, {e_mult, e_div, 2'b00});
    chk("imd_q_wb", {imd_val_q_o[0], imd_val_q_o[1], n_imd_q[0], n_imd_q[1]},
        {m_imd0, m_imd1, m_imd0, m_imd1});
  endtask

  task automatic stall(input int n, input logic [31:0] res, input logic [4:0] rd);
    wb_ready_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1;
      chk("stall_hold", {wb_valid_o, n_wb_valid, issue_ready_o, n_issue_ready}, 4'b1100);
      chk("stall_payload", {wb_data_o, wb_rd_o, n_wb_data, n_wb_rd}, {res, rd, res, rd});
      cyc();
    end
  endtask

  task automatic retire();
    wb_ready_i = 1'b1;
    #1;
    chk("retire_ready", {issue_ready_o, n_issue_ready, wb_valid_o}, 3'b111);
    cyc();
    wb_ready_i = 1'b0;
    #1;
    chk("after_retire", {wb_valid_o, n_wb_valid, issue_ready_o, n_issue_ready}, 4'b0011);
    chk("after_retire_sel", {mult_sel_o, div_sel_o, n_mult_sel, n_div_sel}, 4'b0000);
  endtask

  logic [31:0] r, r_old;
  logic [4:0]  rd_old;
  int          len, wc;

  initial begin
    rst_i = 1'b1;
    issue_valid_i = 1'b0; flush_i = 1'b0; ex_valid_i = 1'b0; wb_ready_i = 1'b0;
    issue_alu_op_i = ALU_ADD; issue_md_op_i = MD_OP_MULL; issue_mult_i = 1'b0; issue_div_i = 1'b0;
    issue_signed_mode_i = 2'b00; issue_op_a_i = '0; issue_op_b_i = '0; issue_rd_i = '0;
    issue_we_i = 1'b0; imd_val_we_i = 2'b00; imd_val_d_i[0] = '0; imd_val_d_i[1] = '0;
    result_ex_i = '0;
    #2;
    // Reset state
    chk("reset_ready", {issue_ready_o, n_issue_ready}, 2'b11);
    chk("reset_strobes", {wb_valid_o, mult_en_o, div_en_o, mult_sel_o, div_sel_o,
                          multdiv_ready_id_o, alu_instr_first_cycle_o}, 7'h00);
    chk("reset_regs", {exec_cycles_o, wb_data_o, wb_rd_o, wb_we_o}, 44'h0);
    chk("reset_imd", {imd_val_q_o[0], imd_val_q_o[1]}, 68'h0);
    cyc();
    cyc();
    rst_i = 1'b0;

    // ADD 5+7 -> rd 3, single EXEC cycle, wb_valid two cycles after accept
    e_alu = ALU_ADD; e_md = MD_OP_MULL; e_mult = 1'b0; e_div = 1'b0; e_sm = 2'b00;
    e_a = 32'd5; e_b = 32'd7; e_rd = 5'd3; e_we = 1'b1;
    accept();
    exec_phase(1, e_a + e_b, 0, 2'b00, '0, '0, 0);
    check_wb(32'd12, 1);
    retire();

    // ex_valid outside EXEC is ignored
    ex_valid_i = 1'b1;
    result_ex_i = $urandom;
    cyc();
    ex_valid_i = 1'b0;
    #1;
    chk("ex_valid_idle", {wb_valid_o, n_wb_valid, issue_ready_o}, 3'b001);

    // 35-cycle DIV with imd[0] written on the first cycle
    rand_instr(2);
    r = $urandom;
    accept();
    exec_phase(35, r, 1, 2'b01, 34'h1_0000_0001, 34'h3_DEAD_BEEF, 0);
    check_wb(r, 35);

    // Back-to-back: hold WB for 3 cycles with a new instruction waiting, then retire + accept
    r_old = r;
    rd_old = e_rd;
    rand_instr(1);
    drive_issue();
    stall(3, r_old, rd_old);
    wb_ready_i = 1'b1;
    #1;
    chk("b2b_wb_valid", {wb_valid_o, n_wb_valid}, 2'b11);
    r = $urandom;
    accept();
    exec_phase(4, r, 2, 2'b10, 34'h0, 34'h2_1234_5678, 0);
    check_wb(r, 4);
    retire();

    // Flush in EXEC cycle 10 of a DIV
    rand_instr(2);
    accept();
    exec_phase(35, $urandom, 3, 2'b11, 34'h0_AAAA_5555, 34'h1_5555_AAAA, 10);
    m_imd0 = '0;
    m_imd1 = '0;
    #1;
    chk("flush_enables", {mult_en_o, div_en_o, n_mult_en, n_div_en, multdiv_ready_id_o}, 5'b0);
    chk("flush_imd", {imd_val_q_o[0], imd_val_q_o[1]}, {m_imd0, m_imd1});
    chk("flush_idle", {wb_valid_o, n_wb_valid, issue_ready_o, n_issue_ready}, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("flush_no_wb", {wb_valid_o, n_wb_valid}, 2'b00);
    end

    // Flush together with issue_valid in IDLE: not accepted
    rand_instr(0);
    drive_issue();
    flush_i = 1'b1;
    #1;
    chk("flush_blocks_issue", {issue_ready_o, n_issue_ready}, 2'b00);
    cyc();
    flush_i = 1'b0;
    issue_valid_i = 1'b0;
    #1;
    chk("flush_not_accepted", {multdiv_ready_id_o, alu_instr_first_cycle_o, n_first}, 3'b000);
    chk("flush_ready_back", {issue_ready_o, n_issue_ready}, 2'b11);

    // Flush in WB with wb_ready: retires
    rand_instr(1);
    r = $urandom;
    accept();
    exec_phase(2, r, 0, 2'b00, '0, '0, 0);
    check_wb(r, 2);
    flush_i = 1'b1;
    wb_ready_i = 1'b1;
    #1;
    chk("flush_wb_retire", {wb_valid_o, n_wb_valid, issue_ready_o, n_issue_ready}, 4'b1100);
    cyc();
    flush_i = 1'b0;
    wb_ready_i = 1'b0;
    #1;
    chk("flush_wb_after", {wb_valid_o, n_wb_valid, issue_ready_o}, 3'b001);

    // Flush in WB without wb_ready: result dropped
    rand_instr(0);
    r = $urandom;
    accept();
    exec_phase(1, r, 0, 2'b00, '0, '0, 0);
    check_wb(r, 1);
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    #1;
    chk("flush_wb_drop", {wb_valid_o, n_wb_valid, issue_ready_o}, 3'b001);

    // Randomized transactions; the first one runs long enough to saturate the cycle counter
    for (int t = 0; t < 10; t++) begin
      rand_instr($urandom_range(0, 2));
      len = (t == 0) ? 70 : $urandom_range(1, 12);
      wc  = $urandom_range(1, len);
      r   = $urandom;
      accept();
      exec_phase(len, r, wc, 2'($urandom), {2'($urandom), 32'($urandom)},
                 {2'($urandom), 32'($urandom)}, 0);
      check_wb(r, len);
      stall($urandom_range(0, 3), r, e_rd);
      retire();
    end

    // Reset in the middle of an operation
    rand_instr(2);
    accept();
    imd_val_we_i = 2'b11;
    imd_val_d_i[0] = 34'h2_0000_00FF;
    imd_val_d_i[1] = 34'h1_FFFF_0000;
    cyc();
    imd_val_we_i = 2'b00;
    cyc();
    rst_i = 1'b1;
    #1;
    chk("rst_mid_ready", {issue_ready_o, n_issue_ready, wb_valid_o, n_wb_valid}, 4'b1100);
    chk("rst_mid_strobes", {mult_en_o, div_en_o, mult_sel_o, div_sel_o,
                            multdiv_ready_id_o, alu_instr_first_cycle_o}, 6'h00);
    chk("rst_mid_regs", {exec_cycles_o, imd_val_q_o[0], imd_val_q_o[1]}, 74'h0);
    cyc();
    rst_i = 1'b0;
    cyc();
    chk("rst_mid_after", {wb_valid_o, issue_ready_o}, 2'b01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
